// File: rtl/rv32i_types_pkg.sv
// Shared RV32I encodings, instruction field layouts and the decoded bundle
// carried by the decode stage.
package rv32i_types;

    localparam int PC_W = 32;

    typedef logic [31:0] instr_t;

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_OP_IMM = 7'b0010011,
        OPC_OP     = 7'b0110011
    } rv32i_opcode;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } load_f3_t;

    typedef enum logic [2:0] {
        F3_SB = 3'b000,
        F3_SH = 3'b001,
        F3_SW = 3'b010
    } store_f3_t;

    typedef enum logic [6:0] {
        F7_BASE    = 7'b0000000,
        F7_VARIANT = 7'b0100000
    } funct7_t;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SR  = 3'b101;

    typedef struct packed {
        logic       imm_b_12;
        logic [5:0] imm_b_10_5;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [3:0] imm_b_4_1;
        logic       imm_b_11;
        logic [6:0] opcode;
    } b_type;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_fmt_t;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [31:0]     imm;
        logic            rs1_used;
        logic            rs2_used;
        logic            rd_we;
        logic            illegal;
    } decoded_t;

endpackage

// File: rtl/rv32i_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
interface rv32i_decode_stage_if
    import rv32i_types::*;
#(
    parameter int XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    instr_t          in_instr;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [6:0]      out_opcode;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic [31:0]     out_imm;
    logic            out_rs1_used;
    logic            out_rs2_used;
    logic            out_rd_we;
    logic            out_illegal;

    modport slave (
        input  flush, in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_opcode, out_funct3, out_funct7,
               out_rs1, out_rs2, out_rd, out_imm, out_rs1_used, out_rs2_used,
               out_rd_we, out_illegal
    );

    modport master (
        output flush, in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_opcode, out_funct3, out_funct7,
               out_rs1, out_rs2, out_rd, out_imm, out_rs1_used, out_rs2_used,
               out_rd_we, out_illegal
    );
endinterface

// File: rtl/rv32i_decode_stage_decoder.sv
// Purely combinational RV32I field extraction, immediate generation and
// legality check. The pc field is left zero; the stage fills it in.
module rv32i_decoder
    import rv32i_types::*;
(
    input  instr_t   instr,
    output decoded_t dec
);
    b_type       b;
    imm_fmt_t    fmt;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        use_rs1;
    logic        use_rs2;
    logic        use_rd;
    logic        has_f3;
    logic        has_f7;
    logic        bad;
    logic [31:0] imm;

    assign b = b_type'(instr);

    always_comb begin
        op      = b.opcode;
        f3      = b.funct3;
        f7      = instr[31:25];
        fmt     = IMM_NONE;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        has_f3  = 1'b1;
        has_f7  = 1'b0;
        bad     = 1'b0;
        case (op)
            OPC_LUI, OPC_AUIPC: begin
                fmt    = IMM_U;
                use_rd = 1'b1;
                has_f3 = 1'b0;
            end
            OPC_JAL: begin
                fmt    = IMM_J;
                use_rd = 1'b1;
                has_f3 = 1'b0;
            end
            OPC_JALR: begin
                fmt     = IMM_I;
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
                bad     = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                fmt     = IMM_B;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                bad     = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OPC_LOAD: begin
                fmt     = IMM_I;
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
                bad     = !(f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
            end
            OPC_STORE: begin
                fmt     = IMM_S;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                bad     = !(f3 inside {F3_SB, F3_SH, F3_SW});
            end
            OPC_OP_IMM: begin
                fmt     = IMM_I;
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
                // shift-immediates reuse the funct7 slot, so it is forwarded and checked
                if (f3 == F3_SLL) begin
                    has_f7 = 1'b1;
                    bad    = (f7 != F7_BASE);
                end else if (f3 == F3_SR) begin
                    has_f7 = 1'b1;
                    bad    = (f7 != F7_BASE) && (f7 != F7_VARIANT);
                end
            end
            OPC_OP: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_rd  = 1'b1;
                has_f7  = 1'b1;
                bad     = !((f7 == F7_BASE) ||
                            ((f7 == F7_VARIANT) && ((f3 == F3_ADD) || (f3 == F3_SR))));
            end
            default: begin
                has_f3 = 1'b0;
                bad    = 1'b1;
            end
        endcase
    end

    always_comb begin
        imm = '0;
        case (fmt)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{b.imm_b_12}}, b.imm_b_12, b.imm_b_11, b.imm_b_10_5,
                            b.imm_b_4_1, 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                            instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

    always_comb begin
        dec          = '0;
        dec.opcode   = op;
        dec.funct3   = has_f3 ? f3 : 3'b000;
        dec.funct7   = has_f7 ? f7 : 7'b0000000;
        dec.rs1      = use_rs1 ? b.rs1 : 5'd0;
        dec.rs2      = use_rs2 ? b.rs2 : 5'd0;
        dec.rd       = use_rd ? instr[11:7] : 5'd0;
        dec.imm      = bad ? 32'd0 : imm;
        dec.rs1_used = use_rs1 && !bad;
        dec.rs2_used = use_rs2 && !bad;
        dec.rd_we    = use_rd && !bad && (instr[11:7] != 5'd0);
        dec.illegal  = bad;
    end
endmodule

// File: rtl/rv32i_decode_stage.sv
// Decode pipeline stage: decoder ahead of a main output register plus a
// one-entry skid register so in_ready can be registered at full throughput.
module rv32i_decode_stage
    import rv32i_types::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_PC_TAG = '0
)
(
    input logic                 clk,
    input logic                 rst_n,
    rv32i_decode_stage_if.slave bus
);
    decoded_t dec_raw;
    decoded_t dec_in;
    decoded_t main_q;
    decoded_t skid_q;
    decoded_t out_q;
    logic     main_valid;
    logic     skid_valid;
    logic     in_fire;
    logic     main_free;

    rv32i_decoder u_decoder (
        .instr (bus.in_instr),
        .dec   (dec_raw)
    );

    always_comb begin
        dec_in    = dec_raw;
        dec_in.pc = bus.in_pc;
    end

    assign in_fire   = bus.in_valid && !skid_valid;
    assign main_free = !main_valid || bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (bus.flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (main_free) begin
            // skid is always older than anything on the input, so it goes first
            if (skid_valid) begin
                main_q     <= skid_q;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else if (in_fire) begin
                main_q     <= dec_in;
                main_valid <= 1'b1;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (in_fire) begin
            skid_q     <= dec_in;
            skid_valid <= 1'b1;
        end
    end

    assign out_q = main_valid ? main_q : '0;

    assign bus.in_ready     = !skid_valid;
    assign bus.out_valid    = main_valid;
    assign bus.out_pc       = main_valid ? main_q.pc : RESET_PC_TAG;
    assign bus.out_opcode   = out_q.opcode;
    assign bus.out_funct3   = out_q.funct3;
    assign bus.out_funct7   = out_q.funct7;
    assign bus.out_rs1      = out_q.rs1;
    assign bus.out_rs2      = out_q.rs2;
    assign bus.out_rd       = out_q.rd;
    assign bus.out_imm      = out_q.imm;
    assign bus.out_rs1_used = out_q.rs1_used;
    assign bus.out_rs2_used = out_q.rs2_used;
    assign bus.out_rd_we    = out_q.rd_we;
    assign bus.out_illegal  = out_q.illegal;
endmodule

// File: tb/tb_rv32i_decode_stage.sv
// Bench for rv32i_decode_stage: directed cases plus random traffic checked
// against a queue model fed by an arithmetic RV32I reference decoder.
module tb_rv32i_decode_stage;

    localparam logic [31:0] TAG = 32'hDEAD_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        rs1_used;
        logic        rs2_used;
        logic        rd_we;
        logic        illegal;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    exp_t q[$];
    logic [6:0] ops[9];

    rv32i_decode_stage_if #(.XLEN(32)) bus ();

    rv32i_decode_stage #(.XLEN(32), .RESET_PC_TAG(TAG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", tag, got, want, $time);
        end
    endtask

    function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
        exp_t        e;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        u1, u2, ud, has3, has7, ill;
        logic [31:0] immv;
        int          t;
        op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
        u1 = 0; u2 = 0; ud = 0; has3 = 0; has7 = 0; ill = 0; immv = 0;
        if (op == 7'h37 || op == 7'h17) begin
            ud = 1; immv = w & 32'hFFFF_F000;
        end else if (op == 7'h6F) begin
            ud = 1;
            t = int'($signed({w[31], w[19:12], w[20], w[30:21]}));
            immv = 32'(t * 2);
        end else if (op == 7'h67) begin
            u1 = 1; ud = 1; has3 = 1; ill = (f3 != 0);
            t = int'($signed(w[31:20])); immv = 32'(t);
        end else if (op == 7'h63) begin
            u1 = 1; u2 = 1; has3 = 1; ill = (f3 == 2 || f3 == 3);
            t = int'($signed({w[31], w[7], w[30:25], w[11:8]}));
            immv = 32'(t * 2);
        end else if (op == 7'h03) begin
            u1 = 1; ud = 1; has3 = 1;
            ill = !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
            t = int'($signed(w[31:20])); immv = 32'(t);
        end else if (op == 7'h23) begin
            u1 = 1; u2 = 1; has3 = 1; ill = (f3 > 2);
            t = int'($signed({w[31:25], w[11:7]})); immv = 32'(t);
        end else if (op == 7'h13) begin
            u1 = 1; ud = 1; has3 = 1;
            t = int'($signed(w[31:20])); immv = 32'(t);
            if (f3 == 1) begin has7 = 1; ill = (f7 != 0); end
            if (f3 == 5) begin has7 = 1; ill = (f7 != 0 && f7 != 7'h20); end
        end else if (op == 7'h33) begin
            u1 = 1; u2 = 1; ud = 1; has3 = 1; has7 = 1;
            ill = !(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)));
        end else begin
            ill = 1;
        end
        e.pc       = pc;
        e.opcode   = op;
        e.funct3   = has3 ? f3 : 3'd0;
        e.funct7   = has7 ? f7 : 7'd0;
        e.rs1      = u1 ? w[19:15] : 5'd0;
        e.rs2      = u2 ? w[24:20] : 5'd0;
        e.rd       = ud ? w[11:7] : 5'd0;
        e.imm      = ill ? 32'd0 : immv;
        e.rs1_used = u1 && !ill;
        e.rs2_used = u2 && !ill;
        e.rd_we    = ud && !ill && (w[11:7] != 0);
        e.illegal  = ill;
        return e;
    endfunction

    task automatic compare_all();
        exp_t e;
        chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
        chk("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
        if (q.size() > 0) e = q[0];
        else begin
            e = '0;
            e.pc = TAG;
        end
        chk("pc", bus.out_pc, e.pc);
        chk("opcode", 32'(bus.out_opcode), 32'(e.opcode));
        chk("funct3", 32'(bus.out_funct3), 32'(e.funct3));
        chk("funct7", 32'(bus.out_funct7), 32'(e.funct7));
        chk("rs1", 32'(bus.out_rs1), 32'(e.rs1));
        chk("rs2", 32'(bus.out_rs2), 32'(e.rs2));
        chk("rd", 32'(bus.out_rd), 32'(e.rd));
        chk("imm", bus.out_imm, e.imm);
        chk("rs1_used", 32'(bus.out_rs1_used), 32'(e.rs1_used));
        chk("rs2_used", 32'(bus.out_rs2_used), 32'(e.rs2_used));
        chk("rd_we", 32'(bus.out_rd_we), 32'(e.rd_we));
        chk("illegal", 32'(bus.out_illegal), 32'(e.illegal));
    endtask

    // Drive one cycle's inputs, advance the model at the edge, check at negedge.
    task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] w,
                         input logic rdy, input logic fl);
        logic acc;
        logic pop;
        bus.in_valid  = v;
        bus.in_pc     = pc;
        bus.in_instr  = w;
        bus.out_ready = rdy;
        bus.flush     = fl;
        @(posedge clk);
        if (fl) q.delete();
        else begin
            acc = v && (q.size() < 2);
            pop = rdy && (q.size() > 0);
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(ref_decode(w, pc));
        end
        @(negedge clk);
        compare_all();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int          k;
        w = $urandom;
        k = $urandom_range(0, 10);
        if (k < 9) w[6:0] = ops[k];
        if ((w[6:0] == 7'h33 || w[6:0] == 7'h13) && $urandom_range(0, 3) != 0)
            w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        return w;
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        ops   = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
        rst_n = 1'b0;
        bus.flush = 0; bus.in_valid = 0; bus.in_pc = 0; bus.in_instr = 0; bus.out_ready = 0;
        repeat (2) @(negedge clk);
        compare_all();
        rst_n = 1'b1;

        cycle(1, 32'h1000, 32'h0050_0093, 1, 0);
        chk("addi_valid", 32'(bus.out_valid), 32'd1);
        chk("addi_pc", bus.out_pc, 32'h1000);
        chk("addi_rd", 32'(bus.out_rd), 32'd1);
        chk("addi_imm", bus.out_imm, 32'h5);
        chk("addi_rd_we", 32'(bus.out_rd_we), 32'd1);
        cycle(1, 32'h1004, 32'hFE20_8CE3, 1, 0);
        chk("beq_imm", bus.out_imm, 32'hFFFF_FFF8);
        chk("beq_rs2_used", 32'(bus.out_rs2_used), 32'd1);
        chk("beq_rd_we", 32'(bus.out_rd_we), 32'd0);
        cycle(1, 32'h1008, 32'h1234_5037, 1, 0);
        chk("lui_imm", bus.out_imm, 32'h1234_5000);
        chk("lui_rd_we", 32'(bus.out_rd_we), 32'd0);
        cycle(1, 32'h100C, 32'h0000_007F, 1, 0);
        chk("bad_op_illegal", 32'(bus.out_illegal), 32'd1);
        cycle(1, 32'h1010, 32'h4000_1033, 1, 0);
        chk("sll_var_illegal", 32'(bus.out_illegal), 32'd1);
        cycle(1, 32'h1014, 32'h4000_5013, 1, 0);
        chk("srai_illegal", 32'(bus.out_illegal), 32'd0);
        chk("srai_rd_we", 32'(bus.out_rd_we), 32'd0);
        cycle(0, 0, 0, 1, 0);

        // back-pressure: two held, third waits upstream
        cycle(1, 32'h2000, 32'h0010_0113, 0, 0);
        cycle(1, 32'h2004, 32'h0020_0193, 0, 0);
        chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        cycle(1, 32'h2008, 32'h0030_0213, 0, 0);
        chk("bp_hold_pc", bus.out_pc, 32'h2000);
        cycle(1, 32'h2008, 32'h0030_0213, 1, 0);
        chk("bp_second", bus.out_pc, 32'h2004);
        cycle(1, 32'h2008, 32'h0030_0213, 1, 0);
        chk("bp_third", bus.out_pc, 32'h2008);
        cycle(0, 0, 0, 1, 0);

        // flush with both entries full and a concurrent input
        cycle(1, 32'h3000, 32'h0050_0093, 0, 0);
        cycle(1, 32'h3004, 32'h0050_0093, 0, 0);
        cycle(1, 32'h3008, 32'h0050_0093, 0, 1);
        chk("flush_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_ready", 32'(bus.in_ready), 32'd1);
        repeat (3) cycle(0, 0, 0, 1, 0);

        // asynchronous reset while holding data
        cycle(1, 32'h4000, 32'h0050_0093, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        chk("arst_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_ready", 32'(bus.in_ready), 32'd1);
        chk("arst_pc", bus.out_pc, TAG);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1, 32'h5000, 32'h0050_0093, 1, 0);
        chk("post_rst_pc", bus.out_pc, 32'h5000);
        chk("post_rst_imm", bus.out_imm, 32'h5);

        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 3) != 0, 32'h8000 + 32'(i * 4), rand_instr(),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
